dmem_cache_ctrl: RTL and testbench
==================================

Name: dmem_cache_ctrl

Overview:
- Blocking, direct-mapped, write-back, write-allocate data cache controller.
- Sits between the pipeline MEM stage and a multi-cycle backing data memory.
- Answers the pipeline's request handshake (valid/ready/hit/output_valid) and issues whole-line read/write transactions to memory on a miss.
- The pipeline stalls every stage whenever !(is_ready && is_hit && is_output_valid).

Parameters:
- NUM_SETS, 16, number of lines; power of two, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- is_input_valid  in  1  request qualifier from pipeline
- addr  in  32  byte address; bits [1:0] ignored
- mem_read  in  1  load request
- mem_write  in  1  store request
- din  in  32  store data
- is_ready  out  1  controller in IDLE, able to accept
- is_output_valid  out  1  dout/hit result valid this cycle
- dout  out  32  load data
- is_hit  out  1  request satisfied this cycle
- mem_req_valid  out  1  backing-memory request
- mem_req_write  out  1  1 = line write-back, 0 = line fill
- mem_req_addr  out  32  line-aligned byte address
- mem_req_wdata  out  32*LINE_WORDS  victim line; word 0 in LSBs
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  fill data valid, one cycle
- mem_resp_rdata  in  32*LINE_WORDS  fill line

Behaviour:
- Address split: offset = addr[2+OB-1:2], index = next IB bits, tag = remainder. OB = log2(LINE_WORDS), IB = log2(NUM_SETS).
- Reset (sync): state ← IDLE; all valid and dirty bits ← 0; mem_req_valid ← 0. Data and tag arrays are not cleared.
- Reset overrides everything, including mid-miss. A late mem_resp_valid after reset is ignored.
- Active request: is_input_valid && (mem_read || mem_write).
- Simultaneous mem_read and mem_write: treated as a write.
- State IDLE:
  - is_ready = 1.
  - hit = !active || (valid[index] && tag match).
  - is_hit = is_output_valid = hit, combinational, zero-latency.
  - dout = selected word on a read hit, else 0.
  - Write hit: at posedge, word ← din and dirty ← 1.
  - Miss: latch index, tag, line address. Next state is WRITEBACK if the victim is valid && dirty, else ALLOCATE.
- State WRITEBACK:
  - mem_req_valid = 1, mem_req_write = 1.
  - mem_req_addr = {victim tag, index, 0}; wdata = victim line.
  - On mem_req_ready: dirty ← 0, go to ALLOCATE.
- State ALLOCATE:
  - mem_req_valid = 1, mem_req_write = 0, addr = latched line address.
  - On mem_req_ready: go to FILL.
- State FILL:
  - mem_req_valid = 0; wait for mem_resp_valid.
  - On mem_resp_valid: write line, tag ← latched tag, valid ← 1, dirty ← 0, go to IDLE.
- In non-IDLE states: is_ready = is_hit = is_output_valid = 0; dout = 0.
- After returning to IDLE, the held request is re-evaluated and hits. A write then merges into the filled line.
- Request dropped mid-miss: the fill still completes and the line is installed.
- mem_resp_valid outside FILL: ignored.
- mem_req_* outputs are registered or derived from state only, never from CPU inputs.
- Miss latency with zero-wait memory: clean miss = 3 cycles stalled; dirty miss = 4.

Optional Feature:
- Macro: DMEM_CACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], both saturating.
  - hit_count increments on each IDLE cycle with an active request that hits.
  - miss_count increments on each IDLE→miss transition.
  - Both clear on reset.
  - A post-fill replay hit does not count as a hit.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_cache_pkg holds:
  - state encoding IDLE/WRITEBACK/ALLOCATE/FILL;
  - the WORD_W = 32 constant;
  - functions deriving OB, IB, and TAG_W from the parameters.
- One sub-module: dmem_cache_line_array.
  - Valid/dirty/tag/data storage: asynchronous read by index.
  - Synchronous write with a word-enable path (store hit) and a line-write path (fill).
  - Synchronous clear of valid/dirty on reset.

Test Plan:
1. After reset, is_input_valid=1 with read=write=0 → is_ready = is_hit = is_output_valid = 1 in the same cycle; mem_req_valid=0.
2. Cold read 0x44; memory has ready=1 and answers line {0x44,0x33,0x22,0x11} one cycle after acceptance:
   - expect ALLOCATE with mem_req_addr=0x40 and write=0;
   - then IDLE with is_hit=1 and dout=0x22;
   - stall cycles = 3.
3. Write 0x48 with din=0xDEAD after scenario 2 → is_hit=1 the same cycle. A following read of 0x48 returns 0xDEAD; read 0x44 still returns 0x22.
4. Read 0x144 (same index 4, new tag) → WRITEBACK first:
   - mem_req_write=1, mem_req_addr=0x40, wdata word 2 = 0xDEAD;
   - hold mem_req_ready=0 for 3 cycles and confirm request/address/data stay stable;
   - then ALLOCATE with addr 0x140.
5. Reset asserted during FILL → next cycle is_ready=1 and mem_req_valid=0. A later mem_resp_valid pulse is ignored, and read 0x44 misses again.
6. With DMEM_CACHE_STATS_EN, run scenarios 2–4 → hit_count=3, miss_count=2. Build without the macro and confirm scenarios 1–5 behave identically.

Source files
------------

// File: rtl/dmem_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_cache_pkg
// Purpose  : Shared constants for the direct-mapped data cache controller.
//            It holds the FSM state encoding, the data word width, and helpers
//            that derive the address-field widths from the cache geometry.
// Contents : WORD_W, ST_IDLE/ST_WRITEBACK/ST_ALLOCATE/ST_FILL,
//            calc_ob(), calc_ib(), calc_tag_w()
// Revision : 1.0 - initial release
// ============================================================================
package dmem_cache_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;
  localparam logic [1:0] ST_FILL      = 2'd3;

  // Number of word-offset bits within a line.
  function automatic int calc_ob(input int line_words);
    return $clog2(line_words);
  endfunction

  // Number of set-index bits.
  function automatic int calc_ib(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag width: the rest of a 32-bit byte address after byte/offset/index bits.
  function automatic int calc_tag_w(input int num_sets, input int line_words);
    return WORD_W - 2 - $clog2(num_sets) - $clog2(line_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_cache_line_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_cache_line_array
// Purpose  : Valid/dirty/tag/data storage for the direct-mapped cache.
//            Two asynchronous read ports: one addressed by the live request
//            index, one by the latched miss index (the victim line).
//            Synchronous writes: a single-word store path and a whole-line
//            fill path. Valid and dirty bits are cleared by reset; tags and
//            data are not.
// Ports    : clk, reset
//            rd_index  -> rd_valid, rd_dirty, rd_tag, rd_line
//            miss_index -> vic_tag, vic_line ; also the target of fill/clean
//            word_we, word_index, word_offset, word_data  (store hit)
//            line_we, line_tag, line_data                 (fill)
//            clean_we                                     (write-back done)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_cache_line_array
  import dmem_cache_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [calc_ib(NUM_SETS)-1:0]            rd_index,
  output logic                                    rd_valid,
  output logic                                    rd_dirty,
  output logic [calc_tag_w(NUM_SETS,LINE_WORDS)-1:0] rd_tag,
  output logic [WORD_W*LINE_WORDS-1:0]            rd_line,
  input  logic [calc_ib(NUM_SETS)-1:0]            miss_index,
  output logic [calc_tag_w(NUM_SETS,LINE_WORDS)-1:0] vic_tag,
  output logic [WORD_W*LINE_WORDS-1:0]            vic_line,
  input  logic                                    word_we,
  input  logic [calc_ib(NUM_SETS)-1:0]            word_index,
  input  logic [calc_ob(LINE_WORDS)-1:0]          word_offset,
  input  logic [WORD_W-1:0]                       word_data,
  input  logic                                    line_we,
  input  logic [calc_tag_w(NUM_SETS,LINE_WORDS)-1:0] line_tag,
  input  logic [WORD_W*LINE_WORDS-1:0]            line_data,
  input  logic                                    clean_we
);

  localparam int TAG_W  = calc_tag_w(NUM_SETS, LINE_WORDS);
  localparam int LINE_W = WORD_W * LINE_WORDS;

  logic [NUM_SETS-1:0] valid_bits;
  logic [NUM_SETS-1:0] dirty_bits;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];

  assign rd_valid = valid_bits[rd_index];
  assign rd_dirty = dirty_bits[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];
  assign vic_tag  = tag_mem[miss_index];
  assign vic_line = data_mem[miss_index];

  // Store, clean and fill never occur in the same cycle (each belongs to a
  // different controller state), so their ordering here is immaterial.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else begin
      if (word_we)  dirty_bits[word_index] <= 1'b1;
      if (clean_we) dirty_bits[miss_index] <= 1'b0;
      if (line_we) begin
        valid_bits[miss_index] <= 1'b1;
        dirty_bits[miss_index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_we)
      data_mem[word_index][int'(word_offset)*WORD_W +: WORD_W] <= word_data;
    if (line_we) begin
      data_mem[miss_index] <= line_data;
      tag_mem[miss_index]  <= line_tag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_cache_ctrl
// Purpose  : Blocking, direct-mapped, write-back, write-allocate data cache
//            controller between the pipeline MEM stage and a multi-cycle
//            line-oriented backing memory.
// Ports    : clk, reset (sync, active-high)
//            CPU side : is_input_valid, addr, mem_read, mem_write, din ->
//                       is_ready, is_output_valid, dout, is_hit
//            Memory   : mem_req_valid/write/addr/wdata, mem_req_ready,
//                       mem_resp_valid, mem_resp_rdata
//            Optional : hit_count, miss_count (saturating)
// Options  : define DMEM_CACHE_STATS_EN to add the hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_cache_ctrl
  import dmem_cache_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          is_input_valid,
  input  logic [31:0]                   addr,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [31:0]                   din,
  output logic                          is_ready,
  output logic                          is_output_valid,
  output logic [31:0]                   dout,
  output logic                          is_hit,
  output logic                          mem_req_valid,
  output logic                          mem_req_write,
  output logic [31:0]                   mem_req_addr,
  output logic [WORD_W*LINE_WORDS-1:0]  mem_req_wdata,
  input  logic                          mem_req_ready,
  input  logic                          mem_resp_valid,
`ifdef DMEM_CACHE_STATS_EN
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count,
`endif
  input  logic [WORD_W*LINE_WORDS-1:0]  mem_resp_rdata
);

  localparam int OB     = calc_ob(LINE_WORDS);
  localparam int IB     = calc_ib(NUM_SETS);
  localparam int TAG_W  = calc_tag_w(NUM_SETS, LINE_WORDS);
  localparam int LINE_W = WORD_W * LINE_WORDS;

  logic [1:0]        state;
  logic [IB-1:0]     miss_index;
  logic [TAG_W-1:0]  miss_tag;

  logic [OB-1:0]     req_offset;
  logic [IB-1:0]     req_index;
  logic [TAG_W-1:0]  req_tag;
  logic              active;
  logic              in_idle;
  logic              tag_match;
  logic              miss;
  logic              word_we;
  logic              line_we;
  logic              clean_we;
  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [TAG_W-1:0]  vic_tag;
  logic [LINE_W-1:0] vic_line;
  logic              unused_byte_bits;

  assign unused_byte_bits = ^addr[1:0];

  assign req_offset = addr[2 +: OB];
  assign req_index  = addr[2+OB +: IB];
  assign req_tag    = addr[31 -: TAG_W];

  assign active    = is_input_valid && (mem_read || mem_write);
  assign in_idle   = (state == ST_IDLE);
  assign tag_match = rd_valid && (rd_tag == req_tag);
  assign miss      = in_idle && active && !tag_match;

  // A combined read+write request is handled as a store.
  assign word_we  = in_idle && active && mem_write && tag_match;
  assign line_we  = (state == ST_FILL) && mem_resp_valid;
  assign clean_we = (state == ST_WRITEBACK) && mem_req_ready;

  assign is_ready        = in_idle;
  assign is_hit          = in_idle && (!active || tag_match);
  assign is_output_valid = is_hit;
  assign dout = (in_idle && active && !mem_write && tag_match)
              ? rd_line[int'(req_offset)*WORD_W +: WORD_W] : '0;

  // Memory-side outputs depend only on state and latched/stored values,
  // so no CPU-input path reaches the memory interface.
  assign mem_req_valid = (state == ST_WRITEBACK) || (state == ST_ALLOCATE);
  assign mem_req_write = (state == ST_WRITEBACK);
  always_comb begin
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (state == ST_WRITEBACK) begin
      mem_req_addr  = {vic_tag, miss_index, {(OB+2){1'b0}}};
      mem_req_wdata = vic_line;
    end else if (state == ST_ALLOCATE) begin
      mem_req_addr  = {miss_tag, miss_index, {(OB+2){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (miss) state <= (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        ST_WRITEBACK: if (mem_req_ready) state <= ST_ALLOCATE;
        ST_ALLOCATE:  if (mem_req_ready) state <= ST_FILL;
        ST_FILL:      if (mem_resp_valid) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (miss) begin
      miss_index <= req_index;
      miss_tag   <= req_tag;
    end
  end

  dmem_cache_line_array #(
    .NUM_SETS   (NUM_SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_lines (
    .clk         (clk),
    .reset       (reset),
    .rd_index    (req_index),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_line     (rd_line),
    .miss_index  (miss_index),
    .vic_tag     (vic_tag),
    .vic_line    (vic_line),
    .word_we     (word_we),
    .word_index  (req_index),
    .word_offset (req_offset),
    .word_data   (din),
    .line_we     (line_we),
    .line_tag    (miss_tag),
    .line_data   (mem_resp_rdata),
    .clean_we    (clean_we)
  );

`ifdef DMEM_CACHE_STATS_EN
  // The first IDLE cycle after a fill is the stalled request being replayed;
  // its hit was already counted as a miss, so it is excluded from hit_count.
  logic replay;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      replay     <= 1'b0;
    end else begin
      replay <= line_we;
      if (in_idle && active && tag_match && !replay && (hit_count != '1))
        hit_count <= hit_count + 32'd1;
      if (miss && (miss_count != '1))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_cache_ctrl
// Purpose  : Self-checking bench for dmem_cache_ctrl (16 sets x 4 words).
//            The bench plays the backing memory and keeps a reference model:
//            a flat word memory of CPU-visible values, the memory contents,
//            and the per-set resident tag/dirty state of a direct-mapped cache.
// Options  : DMEM_CACHE_STATS_EN also checks the hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_cache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid, mem_read, mem_write;
  logic [31:0]  addr, din, dout;
  logic         is_ready, is_output_valid, is_hit;
  logic         mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata, mem_resp_rdata;
`ifdef DMEM_CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dmem_cache_ctrl #(.NUM_SETS(16), .LINE_WORDS(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem_req_valid   (mem_req_valid),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
`ifdef DMEM_CACHE_STATS_EN
    .hit_count       (hit_count),
    .miss_count      (miss_count),
`endif
    .mem_resp_rdata  (mem_resp_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  gold [logic [31:0]];   // CPU-visible word values, keyed by word address
  logic [127:0] bmem [logic [31:0]];   // backing memory lines, keyed by line address
  bit           mv [16];
  bit           md [16];
  logic [23:0]  mt [16];

  int rdy_min = 0, rdy_max = 0, rsp_min = 0, rsp_max = 0;
  bit           fill_pend, req_open;
  int           fill_wait, req_wait;
  logic [31:0]  fill_addr, held_a;
  logic         held_w;
  logic [127:0] held_d;

  function automatic logic [31:0] pat(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] ba);
    logic [31:0]  la;
    logic [127:0] l;
    la = {ba[31:4], 4'b0};
    if (bmem.exists(la)) begin
      l = bmem[la];
      return l[int'(ba[3:2])*32 +: 32];
    end
    return pat(ba >> 2);
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] ba);
    if (gold.exists(ba >> 2)) return gold[ba >> 2];
    return mem_word(ba);
  endfunction

  function automatic logic [127:0] gold_line(input logic [31:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = gold_word(la + 32'(w*4));
    return l;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word(la + 32'(w*4));
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin mv[s] = 0; md[s] = 0; end
    gold.delete();   // dirty data held only in the cache is lost
    fill_pend = 0;
    req_open  = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1; is_input_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      is_input_valid = 0; mem_read = 1'($urandom); mem_write = 1'($urandom);
      addr = $urandom; mem_req_ready = 1'($urandom);
      // stray responses while idle must be ignored
      mem_resp_valid = ($urandom_range(3, 0) == 0);
      mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // One CPU request held until the controller reports a hit; the bench
  // serves the memory side and checks everything against the model.
  task automatic do_req(input logic [31:0] a, input bit vld, input bit rd, input bit wr,
                        input logic [31:0] d, output int stalls);
    logic [3:0]  idx;
    logic [23:0] tg;
    logic [31:0] la, vla;
    bit act, pred_hit, pred_wb, wb_seen, done;
    idx = a[7:4]; tg = a[31:8];
    la  = {a[31:4], 4'b0};
    vla = {mt[idx], idx, 4'b0};
    act      = vld && (rd || wr);
    pred_hit = !act || (mv[idx] && mt[idx] == tg);
    pred_wb  = !pred_hit && mv[idx] && md[idx];
    stalls = 0; done = 0; wb_seen = 0;
    @(negedge clk);
    is_input_valid = vld; addr = a; mem_read = rd; mem_write = wr; din = d;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      mem_req_ready = 0; mem_resp_valid = 0;
      mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (cyc == 0) check("hit_predict", is_hit, pred_hit);
      check("outv_eq_hit", is_output_valid, is_hit);
      if (is_hit) begin
        check("ready_on_hit", is_ready, 1);
        check("no_req_on_hit", mem_req_valid, 0);
        if (act && !wr) check("load_data", dout, gold_word(a));
        else            check("dout_zero", dout, 0);
        if (act) begin
          if (wr) gold[a >> 2] = d;
          md[idx] = (pred_hit ? md[idx] : 1'b0) | wr;
          mv[idx] = 1; mt[idx] = tg;
        end
        done = 1;
      end else begin
        stalls++;
        check("dout_stall", dout, 0);
        if (fill_pend) begin
          if (fill_wait == 0) begin
            mem_resp_valid = 1; mem_resp_rdata = mem_line(fill_addr); fill_pend = 0;
          end else fill_wait--;
        end
        if (mem_req_valid) begin
          if (!req_open) begin
            req_open = 1; req_wait = int'($urandom_range(rdy_max, rdy_min));
            held_w = mem_req_write; held_a = mem_req_addr; held_d = mem_req_wdata;
          end else begin
            check("req_stable_w", mem_req_write, held_w);
            check("req_stable_a", mem_req_addr, held_a);
            check("req_stable_d", mem_req_wdata, held_d);
          end
          if (req_wait == 0) begin
            mem_req_ready = 1; req_open = 0;
            if (mem_req_write) begin
              wb_seen = 1;
              check("wb_addr", mem_req_addr, vla);
              check("wb_data", mem_req_wdata, gold_line(vla));
              bmem[vla] = mem_req_wdata;
            end else begin
              check("fill_addr", mem_req_addr, la);
              fill_pend = 1; fill_wait = int'($urandom_range(rsp_max, rsp_min));
              fill_addr = la;
            end
          end else req_wait--;
        end else if (req_open) begin
          check("req_dropped", 0, 1);
          req_open = 0;
        end
      end
    end
    if (!done) check("req_timeout", 0, 1);
    check("wb_predict", wb_seen, pred_wb);
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    reset = 1; is_input_valid = 0; mem_read = 0; mem_write = 0; addr = 0; din = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    bmem[32'h40] = {32'h44, 32'h33, 32'h22, 32'h11};
    apply_reset();

    // Idle, non-active request: ready and hit at once, no memory traffic.
    @(negedge clk);
    is_input_valid = 1; mem_read = 0; mem_write = 0; addr = $urandom; #1;
    check("t1_ready", is_ready, 1);
    check("t1_hit", is_hit, 1);
    check("t1_outv", is_output_valid, 1);
    check("t1_noreq", mem_req_valid, 0);
    check("t1_dout", dout, 0);

    // Cold read: clean miss, zero-wait memory.
    do_req(32'h44, 1, 1, 0, 0, st);
    check("t2_stalls", st, 3);

    // Store hit, then reads of both words in the line.
    do_req(32'h48, 1, 0, 1, 32'hDEAD, st);
    check("t3_store_stalls", st, 0);
    do_req(32'h48, 1, 1, 0, 0, st);
    do_req(32'h44, 1, 1, 0, 0, st);

    // Conflict miss on a dirty line with a slow memory.
    rdy_min = 3; rdy_max = 3;
    do_req(32'h144, 1, 1, 0, 0, st);
    check("t4_stalls", st, 10);
    rdy_min = 0; rdy_max = 0;

`ifdef DMEM_CACHE_STATS_EN
    @(negedge clk); is_input_valid = 0; #1;
    check("stat_hits", hit_count, 3);
    check("stat_misses", miss_count, 2);
`endif

    // Dirty miss with zero-wait memory.
    do_req(32'h144, 1, 0, 1, 32'hBEEF, st);
    do_req(32'h44, 1, 1, 0, 0, st);
    check("dirty_stalls", st, 4);

    // Reset in the middle of a fill.
    @(negedge clk);
    is_input_valid = 1; addr = 32'h84; mem_read = 1; mem_write = 0; #1;
    check("t5_miss", is_hit, 0);
    @(negedge clk); #1;
    check("t5_alloc_v", mem_req_valid, 1);
    check("t5_alloc_w", mem_req_write, 0);
    check("t5_alloc_a", mem_req_addr, 32'h80);
    mem_req_ready = 1;
    @(negedge clk); #1;
    mem_req_ready = 0;
    check("t5_fill_noreq", mem_req_valid, 0);
    check("t5_fill_busy", is_ready, 0);
    reset = 1; is_input_valid = 0;
    @(negedge clk); #1;
    reset = 0;
    check("t5_ready", is_ready, 1);
    check("t5_noreq", mem_req_valid, 0);
`ifdef DMEM_CACHE_STATS_EN
    check("t5_stat_clr", {hit_count, miss_count}, 0);
`endif
    mem_resp_valid = 1; mem_resp_rdata = {4{32'hBAD0BAD0}};
    @(negedge clk);
    mem_resp_valid = 0;
    model_reset();
    do_req(32'h44, 1, 1, 0, 0, st);
    check("t5_remiss", st, 3);
    do_req(32'h84, 1, 1, 0, 0, st);
    check("t5_late_resp_ignored", st, 3);

    // Randomized traffic over a few conflicting tags/sets.
    rdy_min = 0; rdy_max = 2; rsp_min = 0; rsp_max = 3;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int op;
      a  = ($urandom_range(3, 0) << 8) | ($urandom_range(3, 0) << 4) | $urandom_range(15, 0);
      op = int'($urandom_range(9, 0));
      case (op)
        0:       do_req(a, 0, 1'($urandom), 1'($urandom), $urandom, st);
        1:       do_req(a, 1, 0, 0, $urandom, st);
        2:       do_req(a, 1, 1, 1, $urandom, st);
        3, 4, 5: do_req(a, 1, 0, 1, $urandom, st);
        default: do_req(a, 1, 1, 0, $urandom, st);
      endcase
      if ($urandom_range(4, 0) == 0) idle(int'($urandom_range(3, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
